spi_xfer_sequencer: RTL and testbench

Transaction sequencer that sits directly upstream of spi_master. It buffers outgoing bytes in a TX FIFO and launches one spi_master transfer per byte, driving start/data_in/cpol/cpha. It captures spi_master data_out on each completed transfer into an RX FIFO, which lets system logic stream bursts without hand-timing start pulses.

---
 rtl/spi_xfer_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_sequencer.sv
// Byte sequencer for spi_master: TX FIFO -> one start pulse per byte -> RX FIFO capture.
// Optional transfer watchdog is compiled in when SPI_TIMEOUT_EN is defined.
module spi_xfer_sequencer #(
    parameter int DATA_W         = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_data,
    output logic              spi_cpol,
    output logic              spi_cpha,
    input  logic              spi_done,
    input  logic [DATA_W-1:0] spi_rx,
    output logic              busy,
    output logic              timeout
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t            r_state;
    logic              r_spi_start;
    logic [DATA_W-1:0] r_spi_data;
    logic              r_spi_cpol;
    logic              r_spi_cpha;
    logic [GW-1:0]     r_gap_cnt;
    logic              r_done_q;

    logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_tx_wr;
    logic [AW-1:0]     r_tx_rd;
    logic [CW-1:0]     r_tx_cnt;

    logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_rx_wr;
    logic [AW-1:0]     r_rx_rd;
    logic [CW-1:0]     r_rx_cnt;

    logic w_done_rise;
    logic w_tx_push;
    logic w_rx_pop;
    logic w_launch;
    logic w_capture;

    assign w_done_rise = spi_done & ~r_done_q;
    assign w_tx_push   = tx_valid & tx_ready;
    assign w_rx_pop    = rx_valid & rx_ready;
    // RX space is reserved before launch, so the capture push can never overflow.
    assign w_launch    = (r_state == S_IDLE) & (r_tx_cnt != '0) & (r_rx_cnt != DEPTH_C);
    assign w_capture   = (r_state == S_WAIT_DONE) & w_done_rise;

    assign tx_ready  = (r_tx_cnt != DEPTH_C);
    assign rx_valid  = (r_rx_cnt != '0);
    assign rx_data   = r_rx_mem[r_rx_rd];
    assign spi_start = r_spi_start;
    assign spi_data  = r_spi_data;
    assign spi_cpol  = r_spi_cpol;
    assign spi_cpha  = r_spi_cpha;
    assign busy      = (r_state != S_IDLE) | (r_tx_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= spi_done;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr] <= tx_data;
        end
        if (w_capture) begin
            r_rx_mem[r_rx_wr] <= spi_rx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr <= r_tx_wr + 1'b1;
            end
            if (w_launch) begin
                r_tx_rd <= r_tx_rd + 1'b1;
            end
            case ({w_tx_push, w_launch})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_capture) begin
                r_rx_wr <= r_rx_wr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rd <= r_rx_rd + 1'b1;
            end
            case ({w_capture, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

`ifdef SPI_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [TW-1:0] r_wd_cnt;
    logic          r_timeout;

    assign timeout = r_timeout;
`else
    logic w_unused_timeout_param;

    assign w_unused_timeout_param = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_spi_start <= 1'b0;
            r_spi_data  <= '0;
            r_spi_cpol  <= 1'b0;
            r_spi_cpha  <= 1'b0;
            r_gap_cnt   <= '0;
`ifdef SPI_TIMEOUT_EN
            r_wd_cnt    <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_spi_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state     <= S_LAUNCH;
                        r_spi_start <= 1'b1;
                        r_spi_data  <= r_tx_mem[r_tx_rd];
                        r_spi_cpol  <= cfg_cpol;
                        r_spi_cpha  <= cfg_cpha;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT_DONE;
`ifdef SPI_TIMEOUT_EN
                    r_wd_cnt <= '0;
`endif
                end
                S_WAIT_DONE: begin
                    // Only a rising edge seen inside WAIT_DONE completes the transfer.
                    if (w_done_rise) begin
                        r_gap_cnt <= '0;
                        r_state   <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    end
`ifdef SPI_TIMEOUT_EN
                    else if (r_wd_cnt == WD_LAST) begin
                        r_timeout <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer with a behavioural spi_master stand-in.
`timescale 1ns/1ps
module tb_spi_xfer_sequencer;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int GAP   = 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          cfg_cpol;
    logic          cfg_cpha;
    logic          spi_start;
    logic [DW-1:0] spi_data;
    logic          spi_cpol;
    logic          spi_cpha;
    logic          spi_done;
    logic [DW-1:0] spi_rx;
    logic          busy;
    logic          timeout;

    spi_xfer_sequencer #(
        .DATA_W        (DW),
        .FIFO_DEPTH    (DEPTH),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .cfg_cpol (cfg_cpol),
        .cfg_cpha (cfg_cpha),
        .spi_start(spi_start),
        .spi_data (spi_data),
        .spi_cpol (spi_cpol),
        .spi_cpha (spi_cpha),
        .spi_done (spi_done),
        .spi_rx   (spi_rx),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       cpol;
        logic       cpha;
        int         cyc;
        bit         gap;
    } launch_t;

    launch_t    exp_launch [$];
    logic [7:0] exp_rx     [$];
    logic [7:0] slave_resp [$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_starts = 0;
    int n_rx     = 0;
    int last_done_cyc = -100;
    int slave_lat = 6;
    int s_cnt     = 0;
    int s0;
    int r0;

    logic [7:0] s_val;
    logic [7:0] s_data;
    logic       s_pol;
    logic       s_pha;
    bit         s_unstable;
    bit         prev_start;
    launch_t    mon_e;

    logic [7:0] m_tx  [3] = '{8'h88, 8'h08, 8'hFB};
    logic [7:0] m_rx  [3] = '{8'hC6, 8'h7E, 8'h40};
    logic       m_pol [3] = '{1'b1, 1'b1, 1'b0};
    logic       m_pha [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] b_tx  [8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    logic [7:0] b_rx  [8] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8};
    logic [7:0] k_tx  [10] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [7:0] k_rx  [10] = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7, 8'hD8, 8'hD9};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Monitor plus spi_master stand-in, both evaluated on the falling edge.
    initial begin : monitor
        spi_done = 1'b0;
        spi_rx   = '0;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (rst) begin
                s_cnt      = 0;
                prev_start = 1'b0;
            end else begin
                if (rx_valid && rx_ready) begin
                    n_rx++;
                    if (exp_rx.size() == 0) begin
                        n_checks++;
                        $display("FAIL rx_unexpected: got 0x%0h, expected no data", rx_data);
                    end else begin
                        chk("rx_data", rx_data, exp_rx.pop_front());
                    end
                end
                if (s_cnt > 0) begin
                    if (spi_data !== s_data || spi_cpol !== s_pol || spi_cpha !== s_pha) s_unstable = 1'b1;
                    s_cnt--;
                    if (s_cnt == 0) begin
                        spi_done = 1'b1;
                        spi_rx   = s_val;
                        last_done_cyc = cyc;
                        chk("xfer_hold", s_unstable, 0);
                    end
                end
                if (spi_start) begin
                    n_starts++;
                    chk("start_one_cycle", prev_start, 0);
                    if (exp_launch.size() == 0) begin
                        n_checks++;
                        $display("FAIL launch_unexpected: got data 0x%0h, expected no launch", spi_data);
                    end else begin
                        mon_e = exp_launch.pop_front();
                        chk("launch_word", {spi_cpol, spi_cpha, spi_data}, {mon_e.cpol, mon_e.cpha, mon_e.data});
                        if (mon_e.cyc >= 0) chk("start_latency", cyc, mon_e.cyc);
                        if (mon_e.gap) chk("start_gap", cyc - last_done_cyc, GAP + 2);
                    end
                    s_data     = spi_data;
                    s_pol      = spi_cpol;
                    s_pha      = spi_cpha;
                    s_unstable = 1'b0;
                    s_cnt      = slave_lat;
                    s_val      = (slave_resp.size() != 0) ? slave_resp.pop_front() : 8'h00;
                end
                prev_start = spi_start;
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic [7:0] resp, input bit lat_chk, input bit gap_chk);
        launch_t e;
        int k;
        tx_data  = d;
        tx_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!tx_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) begin
            n_checks++;
            $display("FAIL push_accept: got tx_ready=0 for 0x%0h, expected 1", d);
        end else begin
            e.data = d;
            e.cpol = cfg_cpol;
            e.cpha = cfg_cpha;
            e.cyc  = lat_chk ? cyc + 2 : -1;
            e.gap  = gap_chk;
            exp_launch.push_back(e);
            slave_resp.push_back(resp);
            exp_rx.push_back(resp);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int max_cyc);
        int k;
        k = 0;
        while (n_starts < target && k < max_cyc) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("start_seen", (n_starts >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while ((busy || exp_rx.size() != 0) && k < max_cyc);
        chk("idle_reached", (busy || exp_rx.size() != 0) ? 1 : 0, 0);
    endtask

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin : stimulus
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        rx_ready = 1'b0;
        cfg_cpol = 1'b0;
        cfg_cpha = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_spi_start", spi_start, 0);
        chk("rst_spi_data", spi_data, 0);
        chk("rst_spi_cpol", spi_cpol, 0);
        chk("rst_spi_cpha", spi_cpha, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single byte, mode 0
        rx_ready  = 1'b1;
        slave_lat = 6;
        s0 = n_starts;
        r0 = n_rx;
        push(8'hEA, 8'hCC, 1, 0);
        wait_idle(200);
        chk("single_start_count", n_starts - s0, 1);
        chk("single_rx_count", n_rx - r0, 1);

        // Per-transfer mode switch, cfg flipped mid-transfer must not leak
        for (int i = 0; i < 3; i++) begin
            cfg_cpol = m_pol[i];
            cfg_cpha = m_pha[i];
            s0 = n_starts;
            push(m_tx[i], m_rx[i], 1, 0);
            wait_starts(s0 + 1, 50);
            cfg_cpol = ~cfg_cpol;
            cfg_cpha = ~cfg_cpha;
            wait_idle(200);
        end

        // Burst into a full TX FIFO behind a long transfer
        cfg_cpol  = 1'b0;
        cfg_cpha  = 1'b0;
        slave_lat = 20;
        s0 = n_starts;
        push(8'h11, 8'hA1, 0, 0);
        wait_starts(s0 + 1, 50);
        for (int i = 0; i < 8; i++) push(b_tx[i], b_rx[i], 0, 1);
        chk("tx_full_after_8", tx_ready, 0);
        chk("busy_in_burst", busy, 1);
        wait_idle(1000);
        chk("burst_start_count", n_starts - s0, 9);

        // RX backpressure
        rx_ready  = 1'b0;
        slave_lat = 4;
        s0 = n_starts;
        for (int i = 0; i < 10; i++) push(k_tx[i], k_rx[i], 0, 0);
        repeat (120) @(posedge clk);
        #1;
        chk("bp_start_count", n_starts - s0, 8);
        chk("bp_busy_stall", busy, 1);
        chk("bp_rx_valid", rx_valid, 1);
        chk("bp_rx_head", rx_data, k_rx[0]);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("bp_after_pop_count", n_starts - s0, 9);
        rx_ready = 1'b1;
        wait_idle(500);
        chk("bp_total_count", n_starts - s0, 10);

        // Reset during WAIT_DONE with a second byte still queued
        slave_lat = 20;
        s0 = n_starts;
        push(8'h5A, 8'h99, 0, 0);
        push(8'h6B, 8'h77, 0, 0);
        wait_starts(s0 + 1, 50);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_spi_start", spi_start, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_tx_ready", tx_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_spi_data", spi_data, 0);
        exp_launch.delete();
        slave_resp.delete();
        exp_rx.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s0 = n_starts;
        r0 = n_rx;
        repeat (40) @(posedge clk);
        #1;
        chk("postrst_no_start", n_starts - s0, 0);
        chk("postrst_no_rx", n_rx - r0, 0);
        chk("postrst_rx_valid", rx_valid, 0);

        // Normal operation resumes after reset
        slave_lat = 6;
        s0 = n_starts;
        push(8'h3C, 8'hC3, 1, 0);
        wait_idle(200);
        chk("postrst_start_count", n_starts - s0, 1);
        chk("timeout_low", timeout, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
